// File: rtl/ddr2_sched_pkg.sv
// ddr2_sched_pkg: shared state encodings, MIG commands and burst geometry for the DDR2 scheduler
package ddr2_sched_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WR_D0  = 2'd1;
  localparam logic [1:0] ST_WR_D1  = 2'd2;
  localparam logic [1:0] ST_RD_CMD = 2'd3;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int BURST_WORDS = 2;
  localparam int BURST_COLS  = 4;
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;
endpackage

// File: rtl/ddr2_rd_tracker.sv
// ddr2_rd_tracker: counts read bursts in flight, gates new reads on output-FIFO room, registers returned words
module ddr2_rd_tracker
  import ddr2_sched_pkg::*;
#(
  parameter int APPDATA_WIDTH   = 32,
  parameter int FIFO_CNT_WIDTH  = 11,
  parameter int OB_DEPTH        = 1024,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue,
  input  logic                      rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]  rd_data_fifo_out,
  input  logic [FIFO_CNT_WIDTH-1:0] ob_count,
  output logic                      credit_ok,
  output logic                      rd_busy,
  output logic                      ob_wr_en,
  output logic [APPDATA_WIDTH-1:0]  ob_din
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic phase_q, phase_d;
  logic ob_wr_en_q, ob_wr_en_d;
  logic [APPDATA_WIDTH-1:0] ob_din_q, ob_din_d;
  logic done;
  // a burst completes on its second returned word; credit reserves output-FIFO room for every burst in flight plus the next one
  always_comb begin
    done          = rd_data_valid && phase_q;
    phase_d       = phase_q ^ rd_data_valid;
    outstanding_d = outstanding_q + OW'(issue) - OW'(done);
    ob_wr_en_d    = rd_data_valid;
    ob_din_d      = rd_data_valid ? rd_data_fifo_out : ob_din_q;
    credit_ok     = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                    (int'(ob_count) + BURST_WORDS * (int'(outstanding_q) + 1) <= OB_DEPTH);
  end
  // tracker state and the one-cycle return register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      phase_q       <= 1'b0;
      ob_wr_en_q    <= 1'b0;
      ob_din_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      phase_q       <= phase_d;
      ob_wr_en_q    <= ob_wr_en_d;
      ob_din_q      <= ob_din_d;
    end
  end
  assign rd_busy  = outstanding_q != '0;
  assign ob_wr_en = ob_wr_en_q;
  assign ob_din   = ob_din_q;
endmodule

// File: rtl/ddr2_burst_sched.sv
// ddr2_burst_sched: schedules BL4 write bursts from the input FIFO and BL4 read bursts into the output FIFO over the MIG user interface
module ddr2_burst_sched
  import ddr2_sched_pkg::*;
#(
  parameter int APPDATA_WIDTH   = 32,
  parameter int APP_ADDR_WIDTH  = 31,
  parameter int ADDR_LIMIT      = 33554432,
  parameter int FIFO_CNT_WIDTH  = 11,
  parameter int OB_DEPTH        = 1024,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       phy_init_done,
  input  logic                       wr_mode,
  input  logic                       rd_mode,
  input  logic                       fifo_reset,
  input  logic [APPDATA_WIDTH-1:0]   ib_dout,
  input  logic [FIFO_CNT_WIDTH-1:0]  ib_count,
  output logic                       ib_rd_en,
  input  logic [FIFO_CNT_WIDTH-1:0]  ob_count,
  output logic                       ob_wr_en,
  output logic [APPDATA_WIDTH-1:0]   ob_din,
  output logic [2:0]                 app_af_cmd,
  output logic [APP_ADDR_WIDTH-1:0]  app_af_addr,
  output logic                       app_af_wren,
  input  logic                       app_af_afull,
  output logic [APPDATA_WIDTH-1:0]   app_wdf_data,
  output logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
  output logic                       app_wdf_wren,
  input  logic                       app_wdf_afull,
  input  logic                       rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
  output logic                       busy
);
  localparam int AW = $clog2(ADDR_LIMIT);
  logic [1:0] state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic last_grant_q, last_grant_d;
  logic app_wdf_wren_q, app_wdf_wren_d;
  logic [APPDATA_WIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
  logic app_af_wren_q, app_af_wren_d;
  logic [2:0] app_af_cmd_q, app_af_cmd_d;
  logic [APP_ADDR_WIDTH-1:0] app_af_addr_q, app_af_addr_d;
  logic wr_ok, rd_ok, pick_wr, pick_rd, idle, issue_wr, issue_rd, credit_ok, rd_busy;
  // eligibility, round-robin pick in IDLE, and the fixed WR_D0 -> WR_D1 -> IDLE / RD_CMD -> IDLE sequence
  always_comb begin
    wr_ok    = phy_init_done && wr_mode && (ib_count >= FIFO_CNT_WIDTH'(BURST_WORDS)) &&
               !app_af_afull && !app_wdf_afull;
    rd_ok    = phy_init_done && rd_mode && credit_ok && !app_af_afull;
    pick_wr  = wr_ok && (!rd_ok || last_grant_q == GRANT_RD);
    pick_rd  = rd_ok && !pick_wr;
    idle     = state_q == ST_IDLE;
    issue_wr = state_q == ST_WR_D1;
    issue_rd = state_q == ST_RD_CMD;
    state_d  = idle ? (pick_wr ? ST_WR_D0 : pick_rd ? ST_RD_CMD : ST_IDLE) :
               (state_q == ST_WR_D0) ? ST_WR_D1 : ST_IDLE;
    last_grant_d = fifo_reset ? GRANT_RD :
                   (idle && pick_wr) ? GRANT_WR :
                   (idle && pick_rd) ? GRANT_RD : last_grant_q;
  end
  // address pointers wrap naturally at the power-of-two column space; a pointer clear wins over the advance
  always_comb begin
    wr_addr_d = fifo_reset ? '0 : issue_wr ? wr_addr_q + AW'(BURST_COLS) : wr_addr_q;
    rd_addr_d = fifo_reset ? '0 : issue_rd ? rd_addr_q + AW'(BURST_COLS) : rd_addr_q;
  end
  // MIG strobes are registered one cycle behind the state that produces them
  always_comb begin
    ib_rd_en       = (state_q == ST_WR_D0) || (state_q == ST_WR_D1);
    app_wdf_wren_d = ib_rd_en;
    app_wdf_data_d = ib_rd_en ? ib_dout : app_wdf_data_q;
    app_af_wren_d  = issue_wr || issue_rd;
    app_af_cmd_d   = issue_rd ? CMD_READ : issue_wr ? CMD_WRITE : app_af_cmd_q;
    app_af_addr_d  = issue_rd ? APP_ADDR_WIDTH'(rd_addr_q) :
                     issue_wr ? APP_ADDR_WIDTH'(wr_addr_q) : app_af_addr_q;
  end
  // scheduler state, pointers and registered MIG outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      last_grant_q   <= GRANT_RD;
      app_wdf_wren_q <= 1'b0;
      app_wdf_data_q <= '0;
      app_af_wren_q  <= 1'b0;
      app_af_cmd_q   <= '0;
      app_af_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      last_grant_q   <= last_grant_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_af_wren_q  <= app_af_wren_d;
      app_af_cmd_q   <= app_af_cmd_d;
      app_af_addr_q  <= app_af_addr_d;
    end
  end
  ddr2_rd_tracker #(
    .APPDATA_WIDTH  (APPDATA_WIDTH),
    .FIFO_CNT_WIDTH (FIFO_CNT_WIDTH),
    .OB_DEPTH       (OB_DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_rd_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue           (issue_rd),
    .rd_data_valid   (rd_data_valid),
    .rd_data_fifo_out(rd_data_fifo_out),
    .ob_count        (ob_count),
    .credit_ok       (credit_ok),
    .rd_busy         (rd_busy),
    .ob_wr_en        (ob_wr_en),
    .ob_din          (ob_din)
  );
  assign app_wdf_wren      = app_wdf_wren_q;
  assign app_wdf_data      = app_wdf_data_q;
  assign app_wdf_mask_data = '0;
  assign app_af_wren       = app_af_wren_q;
  assign app_af_cmd        = app_af_cmd_q;
  assign app_af_addr       = app_af_addr_q;
  assign busy              = !idle || rd_busy;
endmodule

// File: tb/tb_ddr2_burst_sched.sv
// tb_ddr2_burst_sched: directed checks of write/read burst scheduling, credit, arbitration, wrap and pointer clear
module tb_ddr2_burst_sched;
  localparam int W = 32, AAW = 31, AL = 64, CW = 11, OBD = 1024, MO = 8;
  logic clk = 1'b0, rst_n = 1'b0, phy_init_done = 1'b0, wr_mode = 1'b0, rd_mode = 1'b0, fifo_reset = 1'b0;
  logic [W-1:0] ib_dout;
  logic [CW-1:0] ib_count;
  logic ib_rd_en;
  logic [CW-1:0] ob_count = '0;
  logic ob_wr_en;
  logic [W-1:0] ob_din;
  logic [2:0] app_af_cmd;
  logic [AAW-1:0] app_af_addr;
  logic app_af_wren, app_af_afull = 1'b0;
  logic [W-1:0] app_wdf_data;
  logic [W/8-1:0] app_wdf_mask_data;
  logic app_wdf_wren, app_wdf_afull = 1'b0;
  logic rd_data_valid = 1'b0;
  logic [W-1:0] rd_data_fifo_out = '0;
  logic busy;
  logic [W-1:0] mem [0:1023];
  int ib_wp = 0, ib_rp = 0, n_pop = 0, n_ret = 0, n_chk = 0, n_pass = 0;
  logic [2:0] cmd_log [$];
  logic [AAW-1:0] addr_log [$];
  logic [W-1:0] wdf_log [$];
  logic [W-1:0] ob_log [$];

  ddr2_burst_sched #(
    .APPDATA_WIDTH(W), .APP_ADDR_WIDTH(AAW), .ADDR_LIMIT(AL),
    .FIFO_CNT_WIDTH(CW), .OB_DEPTH(OBD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .phy_init_done(phy_init_done), .wr_mode(wr_mode),
    .rd_mode(rd_mode), .fifo_reset(fifo_reset), .ib_dout(ib_dout), .ib_count(ib_count),
    .ib_rd_en(ib_rd_en), .ob_count(ob_count), .ob_wr_en(ob_wr_en), .ob_din(ob_din),
    .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr), .app_af_wren(app_af_wren),
    .app_af_afull(app_af_afull), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_afull(app_wdf_afull), .rd_data_valid(rd_data_valid),
    .rd_data_fifo_out(rd_data_fifo_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // first-word-fall-through input FIFO model
  assign ib_count = CW'(ib_wp - ib_rp);
  assign ib_dout  = mem[ib_rp[9:0]];
  always @(posedge clk) if (ib_rd_en) ib_rp <= ib_rp + 1;

  // log every strobe seen on the DUT outputs
  always @(negedge clk) begin
    if (app_af_wren) begin
      cmd_log.push_back(app_af_cmd);
      addr_log.push_back(app_af_addr);
    end
    if (app_wdf_wren) wdf_log.push_back(app_wdf_data);
    if (ob_wr_en) ob_log.push_back(ob_din);
    if (ib_rd_en) n_pop++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[ib_wp[9:0]] = W'(32'h1000 + ib_wp);
      ib_wp++;
    end
  endtask

  task automatic ret(input int n);
    for (int i = 0; i < n; i++) begin
      rd_data_valid    = 1'b1;
      rd_data_fifo_out = W'(32'hA000 + n_ret);
      n_ret++;
      @(negedge clk);
    end
    rd_data_valid = 1'b0;
  endtask

  function automatic int count_cmd(input logic [2:0] c);
    int n = 0;
    foreach (cmd_log[i]) if (cmd_log[i] == c) n++;
    return n;
  endfunction

  function automatic logic [63:0] cmd_at(input int i);
    return (i < cmd_log.size()) ? 64'(cmd_log[i]) : '1;
  endfunction

  function automatic logic [63:0] addr_at(input int i);
    return (i < addr_log.size()) ? 64'(addr_log[i]) : '1;
  endfunction

  task automatic flush;
    rd_mode = 1'b0;
    tick(4);
    ret(2 * count_cmd(3'b001) - n_ret);
    tick(4);
  endtask

  initial begin
    int base, nw, nr, j0, found, bad;
    push(8);
    wr_mode = 1'b1;
    tick(3);
    check("rst_af_wren", app_af_wren, 0);
    check("rst_ib_rd_en", ib_rd_en, 0);
    check("rst_wdf_wren", app_wdf_wren, 0);
    check("rst_ob_wr_en", ob_wr_en, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(10);
    check("noinit_cmds", cmd_log.size(), 0);
    check("noinit_pops", n_pop, 0);
    phy_init_done = 1'b1;
    tick(20);
    check("wr4_cmds", cmd_log.size(), 4);
    check("wr4_pops", n_pop, 8);
    check("mask_zero", app_wdf_mask_data, 0);
    for (int k = 0; k < 4; k++) begin
      check("wr4_cmd", cmd_at(k), 0);
      check("wr4_addr", addr_at(k), 64'(4 * k));
    end
    push(1);
    tick(10);
    check("one_word_idle", cmd_log.size(), 4);
    push(1);
    tick(10);
    check("two_word_cmds", cmd_log.size(), 5);
    check("two_word_addr", addr_at(4), 16);
    wr_mode = 1'b0;
    rd_mode = 1'b1;
    tick(30);
    check("rd8_cmds", cmd_log.size(), 13);
    for (int k = 0; k < 8; k++) begin
      check("rd8_cmd", cmd_at(5 + k), 1);
      check("rd8_addr", addr_at(5 + k), 64'(4 * k));
    end
    check("rd8_busy", busy, 1);
    check("rd8_no_ob", ob_log.size(), 0);
    ret(16);
    tick(2);
    check("ret16_ob", ob_log.size(), 16);
    check("resume_cmd", cmd_at(13), 1);
    check("resume_addr", addr_at(13), 32);
    flush();
    check("flush_busy", busy, 0);
    ob_count = CW'(OBD - 3);
    nr = count_cmd(3'b001);
    rd_mode = 1'b1;
    tick(20);
    check("credit_one", count_cmd(3'b001) - nr, 1);
    ob_count = '0;
    tick(6);
    check("credit_resume", (count_cmd(3'b001) - nr) > 1, 1);
    flush();
    nw = count_cmd(3'b000);
    nr = count_cmd(3'b001);
    base = cmd_log.size();
    push(8);
    wr_mode = 1'b1;
    rd_mode = 1'b1;
    tick(14);
    check("rr_cmd0", cmd_at(base), 0);
    check("rr_cmd1", cmd_at(base + 1), 1);
    check("rr_cmd2", cmd_at(base + 2), 0);
    check("rr_cmd3", cmd_at(base + 3), 1);
    check("rr_waddr0", addr_at(base), 64'((4 * nw) % AL));
    check("rr_raddr0", addr_at(base + 1), 64'((4 * nr) % AL));
    check("rr_waddr1", addr_at(base + 2), 64'((4 * (nw + 1)) % AL));
    check("rr_raddr1", addr_at(base + 3), 64'((4 * (nr + 1)) % AL));
    tick(30);
    wr_mode = 1'b0;
    flush();
    nw = count_cmd(3'b000);
    base = cmd_log.size();
    push(34);
    wr_mode = 1'b1;
    tick(61);
    wr_mode = 1'b0;
    tick(4);
    check("wrap_cmds", cmd_log.size() - base, 17);
    j0 = 15 - (nw % 16);
    check("wrap_top", addr_at(base + j0), AL - 4);
    check("wrap_zero", addr_at(base + j0 + 1), 0);
    nw = count_cmd(3'b000);
    base = cmd_log.size();
    push(6);
    wr_mode = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (ib_rd_en) found = 1;
    end
    check("clr_wait_burst", found, 1);
    @(negedge clk);
    fifo_reset = 1'b1;
    @(negedge clk);
    fifo_reset = 1'b0;
    tick(15);
    wr_mode = 1'b0;
    check("clr_cmds", cmd_log.size() - base, 3);
    check("clr_inflight", addr_at(base), 64'((4 * nw) % AL));
    check("clr_wr0", addr_at(base + 1), 0);
    check("clr_wr1", addr_at(base + 2), 4);
    base = cmd_log.size();
    rd_mode = 1'b1;
    tick(3);
    check("clr_rd_cmd", cmd_at(base), 1);
    check("clr_rd_addr", addr_at(base), 0);
    flush();
    check("end_busy", busy, 0);
    bad = 0;
    foreach (wdf_log[i]) if (wdf_log[i] != W'(32'h1000 + i)) bad++;
    check("wdf_data", bad, 0);
    check("wdf_count", wdf_log.size(), n_pop);
    bad = 0;
    foreach (ob_log[i]) if (ob_log[i] != W'(32'hA000 + i)) bad++;
    check("ob_data", bad, 0);
    check("ob_count", ob_log.size(), n_ret);
    bad = 0;
    foreach (addr_log[i]) if ((addr_log[i] >> 6) != 0) bad++;
    check("addr_upper", bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
